// File: rtl/program_memory_fetch_arbiter.sv
// Two-way arbiter for the single ProgramMemory read port. Instruction fetch has priority,
// and a starvation guard bounds the debug port's wait. The response is registered one cycle after the grant.
module program_memory_fetch_arbiter #(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h00400000,
  parameter int                    STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic                  if_err,
  input  logic                  dbg_req,
  input  logic [DATA_WIDTH-1:0] dbg_addr,
  output logic                  dbg_gnt,
  output logic                  dbg_valid,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  dbg_err,
  output logic [DATA_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_instr
);

  localparam int                CNT_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [DATA_WIDTH:0] TEXT_END = {1'b0, TEXT_BASE} + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

  typedef enum logic {
    IF_PRI    = 1'b0,
    DBG_FORCE = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CNT_W-1:0]        r_starve_cnt;
  logic [CNT_W-1:0]        w_cnt_next;

  logic                    w_if_gnt;
  logic                    w_dbg_gnt;
  logic                    w_if_legal;
  logic                    w_dbg_legal;
  logic                    w_sel_legal;
  logic [DATA_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_rom_addr;

  logic                    r_if_valid;
  logic                    r_if_err;
  logic [DATA_WIDTH-1:0]   r_if_instr;
  logic                    r_dbg_valid;
  logic                    r_dbg_err;
  logic [DATA_WIDTH-1:0]   r_dbg_data;

  // Word-aligned and inside [TEXT_BASE, TEXT_BASE + 4*MEMORY_DEPTH), unsigned and full width.
  function automatic logic addr_legal(input logic [DATA_WIDTH-1:0] a);
    return (a[1:0] == 2'b00) && (a >= TEXT_BASE) && ({1'b0, a} < TEXT_END);
  endfunction

  assign w_if_legal  = addr_legal(if_addr);
  assign w_dbg_legal = addr_legal(dbg_addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IF_PRI;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_cnt_next;
    end
  end

  always_comb begin
    w_if_gnt     = 1'b0;
    w_dbg_gnt    = 1'b0;
    w_state_next = r_state;
    w_cnt_next   = r_starve_cnt;

    if (reset) begin
      case (r_state)
        IF_PRI: begin
          w_if_gnt  = if_req;
          w_dbg_gnt = dbg_req & ~if_req;
        end
        DBG_FORCE: begin
          w_dbg_gnt = dbg_req;
          w_if_gnt  = if_req & ~dbg_req;
        end
        default: begin
          w_if_gnt  = 1'b0;
          w_dbg_gnt = 1'b0;
        end
      endcase
    end

    if (!dbg_req || w_dbg_gnt) begin
      w_cnt_next = '0;
    end else if (w_if_gnt && (r_starve_cnt != CNT_LIMIT)) begin
      w_cnt_next = r_starve_cnt + CNT_W'(1);
    end

    // Switching on the incoming count gives DBG the slot right after the LIMIT-th IF grant.
    case (r_state)
      IF_PRI: begin
        if (w_cnt_next == CNT_LIMIT) begin
          w_state_next = DBG_FORCE;
        end
      end
      DBG_FORCE: begin
        if (w_if_gnt || w_dbg_gnt) begin
          w_state_next = IF_PRI;
        end
      end
      default: w_state_next = IF_PRI;
    endcase
  end

  assign w_sel_addr  = w_dbg_gnt ? dbg_addr : if_addr;
  assign w_sel_legal = w_dbg_gnt ? w_dbg_legal : w_if_legal;
  assign w_rom_addr  = ((w_if_gnt || w_dbg_gnt) && w_sel_legal) ? w_sel_addr : TEXT_BASE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_valid  <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_instr  <= '0;
      r_dbg_valid <= 1'b0;
      r_dbg_err   <= 1'b0;
      r_dbg_data  <= '0;
    end else begin
      r_if_valid  <= w_if_gnt;
      r_if_err    <= w_if_gnt & ~w_if_legal;
      r_dbg_valid <= w_dbg_gnt;
      r_dbg_err   <= w_dbg_gnt & ~w_dbg_legal;
      // Data words hold between responses; a faulting access returns zero.
      if (w_if_gnt) begin
        r_if_instr <= w_if_legal ? rom_instr : '0;
      end
      if (w_dbg_gnt) begin
        r_dbg_data <= w_dbg_legal ? rom_instr : '0;
      end
    end
  end

  assign if_gnt    = w_if_gnt;
  assign dbg_gnt   = w_dbg_gnt;
  assign rom_addr  = w_rom_addr;
  assign if_valid  = r_if_valid;
  assign if_err    = r_if_err;
  assign if_instr  = r_if_instr;
  assign dbg_valid = r_dbg_valid;
  assign dbg_err   = r_dbg_err;
  assign dbg_data  = r_dbg_data;

endmodule

// File: tb/tb_program_memory_fetch_arbiter.sv
// Scoreboard bench for program_memory_fetch_arbiter: directed scenarios plus randomized
// request traffic, compared against a behavioural arbitration model and a ROM array.
module tb_program_memory_fetch_arbiter;

  localparam int          DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h00400000;
  localparam int          LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dbg_req;
  logic [31:0] if_addr, dbg_addr;
  logic        if_gnt, if_valid, if_err;
  logic        dbg_gnt, dbg_valid, dbg_err;
  logic [31:0] if_instr, dbg_data, rom_addr, rom_instr;

  logic [31:0] rom_mem [0:DEPTH-1];
  logic [31:0] rom_off;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t if_q[$];
  resp_t dbg_q[$];

  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  bit  forced = 0;
  int  streak = 0;
  logic g_i, g_d;

  program_memory_fetch_arbiter #(
    .MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32), .TEXT_BASE(BASE), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_instr(if_instr), .if_err(if_err),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_err(dbg_err),
    .rom_addr(rom_addr), .rom_instr(rom_instr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    rom_off   = rom_addr - BASE;
    rom_instr = 32'hDEADBEEF;
    if (rom_addr >= BASE && rom_off < 32'(4 * DEPTH)) rom_instr = rom_mem[rom_off[6:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    longint unsigned v;
    v = a;
    return (v % 4 == 0) && (v >= BASE) && (v < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    int idx;
    idx = int'((a - BASE) / 4);
    return rom_mem[idx];
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0: return BASE + 32'($urandom_range(0, 127));
      1: return BASE - 32'(4 * $urandom_range(1, 4));
      2: return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
      3: return $urandom;
      default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  task automatic assert_reset();
    reset = 1'b0;
    if_q.delete();
    dbg_q.delete();
    forced = 0;
    streak = 0;
  endtask

  // One cycle of stimulus: drive, let grants settle, compare against the model, record expected responses.
  task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                       output logic eig, output logic edg);
    resp_t       r;
    logic [31:0] exp_rom;
    if_req = ir; if_addr = ia; dbg_req = dr; dbg_addr = da;
    #1;
    if (forced) begin
      edg = dr;
      eig = ir && !dr;
    end else begin
      eig = ir;
      edg = dr && !ir;
    end
    check("if_gnt", {31'd0, if_gnt}, {31'd0, eig});
    check("dbg_gnt", {31'd0, dbg_gnt}, {31'd0, edg});
    exp_rom = BASE;
    if (eig) begin
      r.due = cyc + 1; r.err = !legal(ia); r.data = legal(ia) ? word_of(ia) : 32'd0;
      if_q.push_back(r);
      if (legal(ia)) exp_rom = ia;
    end
    if (edg) begin
      r.due = cyc + 1; r.err = !legal(da); r.data = legal(da) ? word_of(da) : 32'd0;
      dbg_q.push_back(r);
      if (legal(da)) exp_rom = da;
    end
    check("rom_addr", rom_addr, exp_rom);
    if (forced && (eig || edg)) forced = 0;
    if (!dr || edg) streak = 0;
    else if (eig) streak++;
    if (streak >= LIMIT) forced = 1;
    @(negedge clk);
  endtask

  // Monitor: response side, decoupled from stimulus via the queues.
  logic [31:0] last_if = 0, last_dbg = 0;
  always @(negedge clk) begin
    resp_t r;
    bit    ev;
    if (!reset) begin
      check("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
      check("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
      check("rst_if_valid", {31'd0, if_valid}, 32'd0);
      check("rst_dbg_valid", {31'd0, dbg_valid}, 32'd0);
      check("rst_if_err", {31'd0, if_err}, 32'd0);
      check("rst_dbg_err", {31'd0, dbg_err}, 32'd0);
      check("rst_if_instr", if_instr, 32'd0);
      check("rst_dbg_data", dbg_data, 32'd0);
      last_if = 0;
      last_dbg = 0;
    end else begin
      ev = (if_q.size() > 0) && (if_q[0].due == cyc);
      check("if_valid", {31'd0, if_valid}, {31'd0, ev});
      if (ev) begin
        r = if_q.pop_front();
        if (if_valid) begin
          check("if_instr", if_instr, r.data);
          check("if_err", {31'd0, if_err}, {31'd0, r.err});
          last_if = if_instr;
        end
      end else if (!if_valid) begin
        check("if_err_idle", {31'd0, if_err}, 32'd0);
        check("if_instr_hold", if_instr, last_if);
      end else begin
        last_if = if_instr;
      end
      ev = (dbg_q.size() > 0) && (dbg_q[0].due == cyc);
      check("dbg_valid", {31'd0, dbg_valid}, {31'd0, ev});
      if (ev) begin
        r = dbg_q.pop_front();
        if (dbg_valid) begin
          check("dbg_data", dbg_data, r.data);
          check("dbg_err", {31'd0, dbg_err}, {31'd0, r.err});
          last_dbg = dbg_data;
        end
      end else if (!dbg_valid) begin
        check("dbg_err_idle", {31'd0, dbg_err}, 32'd0);
        check("dbg_data_hold", dbg_data, last_dbg);
      end else begin
        last_dbg = dbg_data;
      end
    end
  end

  initial begin
    logic        ip, dp;
    logic [31:0] ia, da;
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = $urandom;
    rom_mem[2] = 32'h2008000A;
    reset = 1'b1;
    if_req = 1'b1; if_addr = BASE; dbg_req = 1'b0; dbg_addr = BASE;
    #1;
    assert_reset();
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    cycle(1'b1, BASE, 1'b0, BASE, g_i, g_d);

    cycle(1'b1, 32'h00400008, 1'b0, BASE, g_i, g_d);
    cycle(1'b1, 32'h00400002, 1'b0, BASE, g_i, g_d);
    cycle(1'b1, 32'h003FFFFC, 1'b0, BASE, g_i, g_d);
    cycle(1'b1, 32'h00400080, 1'b0, BASE, g_i, g_d);
    cycle(1'b0, BASE, 1'b1, 32'h0040007C, g_i, g_d);
    cycle(1'b0, BASE, 1'b1, 32'hFFFFFFFC, g_i, g_d);
    cycle(1'b0, BASE, 1'b0, BASE, g_i, g_d);

    for (int k = 0; k < 10; k++) cycle(1'b1, BASE + 32'(4 * k), 1'b1, BASE + 32'h40, g_i, g_d);

    for (int k = 0; k < 6; k++) cycle(1'b0, BASE, 1'b1, BASE + 32'(4 * k), g_i, g_d);
    for (int k = 0; k < 4; k++) cycle(1'b1, BASE + 32'h10, 1'b1, BASE + 32'h14, g_i, g_d);
    cycle(1'b1, BASE + 32'h18, 1'b0, BASE, g_i, g_d);
    cycle(1'b1, BASE + 32'h1C, 1'b1, BASE + 32'h20, g_i, g_d);
    for (int k = 0; k < 3; k++) cycle(1'b1, BASE + 32'h10, 1'b1, BASE + 32'h20, g_i, g_d);
    cycle(1'b0, BASE, 1'b0, BASE, g_i, g_d);
    cycle(1'b1, BASE + 32'h24, 1'b1, BASE + 32'h28, g_i, g_d);

    if_req = 1'b1; if_addr = BASE + 32'h4; dbg_req = 1'b0;
    #1 check("t6_if_gnt", {31'd0, if_gnt}, 32'd1);
    @(posedge clk);
    #1 assert_reset();
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 10; k++) cycle(1'b1, BASE + 32'(4 * k), 1'b1, BASE + 32'h7C, g_i, g_d);

    ip = 0; dp = 0; ia = BASE; da = BASE;
    for (int k = 0; k < 400; k++) begin
      if (!ip) begin ip = ($urandom_range(0, 99) < 60); ia = rand_addr(); end
      if (!dp) begin dp = ($urandom_range(0, 99) < 45); da = rand_addr(); end
      cycle(ip, ia, dp, da, g_i, g_d);
      if (g_i) ip = 0;
      if (g_d) dp = 0;
    end

    if_req = 1'b0; dbg_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("drain_if_q", 32'(if_q.size()), 32'd0);
    check("drain_dbg_q", 32'(dbg_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
